game_object_engine: RTL

Parametrised successor to the single-purpose scrolling-bar and obstacle movers. It holds NUM_OBJ rectangular game objects, moves every enabled object one STEP per movement tick, and applies either wrap-around or bounce at the screen edges. It registers player-vs-object collision and produces the per-direction move-block flags and a hit event. It sits between the keyboard/player logic and the VGA renderer, which reads the flattened position buses.

---
 rtl/game_object_engine.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/game_object_engine.sv
// Multi-object mover: steps every enabled rectangle once per movement tick with wrap or
// bounce at the screen edges, and registers player collision flags and hit events.
module game_object_engine #(
  parameter int unsigned NUM_OBJ  = 8,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned H_MAX    = 640,
  parameter int unsigned V_MAX    = 480,
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned STEP     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_idx,
  input  logic [COORD_W-1:0]     cfg_hpos,
  input  logic [COORD_W-1:0]     cfg_vpos,
  input  logic [COORD_W-1:0]     cfg_width,
  input  logic [COORD_W-1:0]     cfg_height,
  input  logic [1:0]             cfg_dir,
  input  logic                   cfg_mode,
  input  logic                   cfg_en,
  input  logic [COORD_W-1:0]     plr_hpos,
  input  logic [COORD_W-1:0]     plr_vpos,
  input  logic [COORD_W-1:0]     plr_width,
  input  logic [COORD_W-1:0]     plr_height,
  output logic [NUM_OBJ*COORD_W-1:0] obj_hpos,
  output logic [NUM_OBJ*COORD_W-1:0] obj_vpos,
  output logic [NUM_OBJ*2-1:0]   obj_dir,
  output logic [NUM_OBJ-1:0]     obj_en,
  output logic                   block_up,
  output logic                   block_down,
  output logic                   block_left,
  output logic                   block_right,
  output logic                   hit_pulse,
  output logic [3:0]             hit_idx,
  output logic                   tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW   = COORD_W + 1;  // movement arithmetic width
  localparam int unsigned OW   = COORD_W + 2;  // overlap arithmetic width (shift + size)

  localparam logic [SW-1:0]   HMax    = SW'(H_MAX);
  localparam logic [SW-1:0]   VMax    = SW'(V_MAX);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
  localparam logic [OW-1:0]   StepO   = OW'(STEP);

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               flip;
  } step_t;

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_w;

  assign tick_w = (cnt_q == CntLast);

  always_comb begin
    cnt_d = tick_w ? '0 : cnt_q + CntW'(1);
  end

  // ---------------------------------------------------------------------------
  // Object state
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] hpos_q   [NUM_OBJ];
  logic [COORD_W-1:0] hpos_d   [NUM_OBJ];
  logic [COORD_W-1:0] vpos_q   [NUM_OBJ];
  logic [COORD_W-1:0] vpos_d   [NUM_OBJ];
  logic [COORD_W-1:0] width_q  [NUM_OBJ];
  logic [COORD_W-1:0] width_d  [NUM_OBJ];
  logic [COORD_W-1:0] height_q [NUM_OBJ];
  logic [COORD_W-1:0] height_d [NUM_OBJ];
  logic [1:0]         dir_q    [NUM_OBJ];
  logic [1:0]         dir_d    [NUM_OBJ];
  logic               mode_q   [NUM_OBJ];
  logic               mode_d   [NUM_OBJ];
  logic               en_q     [NUM_OBJ];
  logic               en_d     [NUM_OBJ];

  // One axis step; neg selects the decreasing direction (left/up).
  function automatic step_t move_axis(input logic [COORD_W-1:0] pos,
                                      input logic [COORD_W-1:0] size,
                                      input logic               neg,
                                      input logic               bounce,
                                      input logic [SW-1:0]      lim);
    logic [SW-1:0] p, s, st;
    step_t         r;
    p      = SW'(pos);
    s      = SW'(size);
    st     = SW'(STEP);
    r.pos  = pos;
    r.flip = 1'b0;
    if (bounce) begin
      if (!neg && (p + s + st > lim)) begin
        r.flip = 1'b1;
      end else if (neg && (p < st)) begin
        r.flip = 1'b1;
      end else begin
        r.pos = neg ? COORD_W'(p - st) : COORD_W'(p + st);
      end
    end else if (!neg) begin
      r.pos = (p + st >= lim) ? COORD_W'(p + st - lim) : COORD_W'(p + st);
    end else begin
      r.pos = (p < st) ? COORD_W'(p + lim - st) : COORD_W'(p - st);
    end
    return r;
  endfunction

  step_t mv;
  logic  vert;

  always_comb begin
    mv   = '0;
    vert = 1'b0;
    for (int i = 0; i < int'(NUM_OBJ); i++) begin
      hpos_d[i]   = hpos_q[i];
      vpos_d[i]   = vpos_q[i];
      width_d[i]  = width_q[i];
      height_d[i] = height_q[i];
      dir_d[i]    = dir_q[i];
      mode_d[i]   = mode_q[i];
      en_d[i]     = en_q[i];
      // A config write beats movement for the addressed object only.
      if (cfg_we && (cfg_idx == 4'(i))) begin
        hpos_d[i]   = cfg_hpos;
        vpos_d[i]   = cfg_vpos;
        width_d[i]  = cfg_width;
        height_d[i] = cfg_height;
        dir_d[i]    = cfg_dir;
        mode_d[i]   = cfg_mode;
        en_d[i]     = cfg_en;
      end else if (tick_w && en_q[i]) begin
        vert = dir_q[i][1];
        mv   = move_axis(vert ? vpos_q[i] : hpos_q[i],
                         vert ? height_q[i] : width_q[i],
                         dir_q[i][0], mode_q[i], vert ? VMax : HMax);
        if (vert) begin
          vpos_d[i] = mv.pos;
        end else begin
          hpos_d[i] = mv.pos;
        end
        // Reversal toggles right<->left or down<->up.
        if (mv.flip) begin
          dir_d[i] = dir_q[i] ^ 2'b01;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Collision
  // ---------------------------------------------------------------------------
  function automatic logic overlap(input logic [OW-1:0] ah, input logic [OW-1:0] av,
                                   input logic [OW-1:0] aw, input logic [OW-1:0] ahh,
                                   input logic [OW-1:0] bh, input logic [OW-1:0] bv,
                                   input logic [OW-1:0] bw, input logic [OW-1:0] bhh);
    return (ah < bh + bw) && (bh < ah + aw) && (av < bv + bhh) && (bv < av + ahh);
  endfunction

  logic [OW-1:0] ph, pv, pw, phh;
  logic          left_ok, up_ok;
  logic          any_hit, blk_r, blk_l, blk_d, blk_u;
  logic [3:0]    hit_low;

  assign ph      = OW'(plr_hpos);
  assign pv      = OW'(plr_vpos);
  assign pw      = OW'(plr_width);
  assign phh     = OW'(plr_height);
  assign left_ok = (ph >= StepO);
  assign up_ok   = (pv >= StepO);

  always_comb begin
    any_hit = 1'b0;
    hit_low = '0;
    blk_r   = 1'b0;
    blk_l   = 1'b0;
    blk_d   = 1'b0;
    blk_u   = 1'b0;
    // Descending scan so the lowest overlapping index is written last.
    for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
      if (en_q[i]) begin
        if (overlap(ph, pv, pw, phh, OW'(hpos_q[i]), OW'(vpos_q[i]),
                    OW'(width_q[i]), OW'(height_q[i]))) begin
          any_hit = 1'b1;
          hit_low = 4'(i);
        end
        if (overlap(ph + StepO, pv, pw, phh, OW'(hpos_q[i]), OW'(vpos_q[i]),
                    OW'(width_q[i]), OW'(height_q[i]))) begin
          blk_r = 1'b1;
        end
        if (left_ok && overlap(ph - StepO, pv, pw, phh, OW'(hpos_q[i]), OW'(vpos_q[i]),
                               OW'(width_q[i]), OW'(height_q[i]))) begin
          blk_l = 1'b1;
        end
        if (overlap(ph, pv + StepO, pw, phh, OW'(hpos_q[i]), OW'(vpos_q[i]),
                    OW'(width_q[i]), OW'(height_q[i]))) begin
          blk_d = 1'b1;
        end
        if (up_ok && overlap(ph, pv - StepO, pw, phh, OW'(hpos_q[i]), OW'(vpos_q[i]),
                             OW'(width_q[i]), OW'(height_q[i]))) begin
          blk_u = 1'b1;
        end
      end
    end
  end

  logic       blk_r_q, blk_r_d, blk_l_q, blk_l_d, blk_d_q, blk_d_d, blk_u_q, blk_u_d;
  logic       hit_pulse_q, hit_pulse_d, any_hit_prev_q, any_hit_prev_d;
  logic [3:0] hit_idx_q, hit_idx_d;

  always_comb begin
    blk_r_d        = blk_r;
    blk_l_d        = blk_l;
    blk_d_d        = blk_d;
    blk_u_d        = blk_u;
    any_hit_prev_d = any_hit;
    hit_pulse_d    = any_hit & ~any_hit_prev_q;
    hit_idx_d      = hit_pulse_d ? hit_low : hit_idx_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      blk_r_q        <= 1'b0;
      blk_l_q        <= 1'b0;
      blk_d_q        <= 1'b0;
      blk_u_q        <= 1'b0;
      hit_pulse_q    <= 1'b0;
      hit_idx_q      <= '0;
      any_hit_prev_q <= 1'b0;
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
        hpos_q[i]   <= '0;
        vpos_q[i]   <= '0;
        width_q[i]  <= '0;
        height_q[i] <= '0;
        dir_q[i]    <= '0;
        mode_q[i]   <= 1'b0;
        en_q[i]     <= 1'b0;
      end
    end else begin
      cnt_q          <= cnt_d;
      blk_r_q        <= blk_r_d;
      blk_l_q        <= blk_l_d;
      blk_d_q        <= blk_d_d;
      blk_u_q        <= blk_u_d;
      hit_pulse_q    <= hit_pulse_d;
      hit_idx_q      <= hit_idx_d;
      any_hit_prev_q <= any_hit_prev_d;
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
        hpos_q[i]   <= hpos_d[i];
        vpos_q[i]   <= vpos_d[i];
        width_q[i]  <= width_d[i];
        height_q[i] <= height_d[i];
        dir_q[i]    <= dir_d[i];
        mode_q[i]   <= mode_d[i];
        en_q[i]     <= en_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    obj_hpos = '0;
    obj_vpos = '0;
    obj_dir  = '0;
    obj_en   = '0;
    for (int i = 0; i < int'(NUM_OBJ); i++) begin
      obj_hpos[i*COORD_W +: COORD_W] = hpos_q[i];
      obj_vpos[i*COORD_W +: COORD_W] = vpos_q[i];
      obj_dir[i*2 +: 2]              = dir_q[i];
      obj_en[i]                      = en_q[i];
    end
  end

  assign tick        = tick_w;
  assign block_right = blk_r_q;
  assign block_left  = blk_l_q;
  assign block_down  = blk_d_q;
  assign block_up    = blk_u_q;
  assign hit_pulse   = hit_pulse_q;
  assign hit_idx     = hit_idx_q;

endmodule
